// File: rtl/l2_snoop_responder.sv
// L2 snoop responder: accepts one snooped bus operation at a time, looks up the
// L2 tags, answers NOHIT/HIT/HITM, writes back modified lines and updates the
// MESI state of the hitting way.
module l2_snoop_responder #(
    parameter int PA_BITS    = 32,
    parameter int L2_ASSOC   = 8,
    parameter int L2_LINE_SZ = 64,
    localparam int WAY_W     = $clog2(L2_ASSOC),
    localparam int OFF_W     = $clog2(L2_LINE_SZ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               snp_valid,
    output logic               snp_ready,
    input  logic [3:0]         snp_cmd,
    input  logic [PA_BITS-1:0] snp_addr,
    output logic               tl_req,
    output logic [PA_BITS-1:0] tl_addr,
    input  logic               tl_ack,
    input  logic               tl_hit,
    input  logic [WAY_W-1:0]   tl_way,
    input  logic [1:0]         tl_mesi,
    output logic               tu_we,
    output logic [PA_BITS-1:0] tu_addr,
    output logic [WAY_W-1:0]   tu_way,
    output logic [1:0]         tu_mesi,
    output logic               snp_resp_valid,
    output logic [1:0]         snp_resp,
    output logic               bus_req,
    output logic [2:0]         bus_op,
    output logic [PA_BITS-1:0] bus_addr,
    input  logic               bus_gnt,
    output logic               snp_err,
    output logic               busy,
    output logic [15:0]        snp_cnt,
    output logic [15:0]        hitm_cnt
);

    localparam logic [3:0] CMD_INV  = 4'd3;
    localparam logic [3:0] CMD_RD   = 4'd4;
    localparam logic [3:0] CMD_WR   = 4'd5;
    localparam logic [3:0] CMD_RWIM = 4'd6;

    localparam logic [1:0] MESI_INV  = 2'd0;
    localparam logic [1:0] MESI_MOD  = 2'd1;
    localparam logic [1:0] MESI_EXCL = 2'd2;
    localparam logic [1:0] MESI_SHRD = 2'd3;

    localparam logic [1:0] RESP_NOHIT = 2'd0;
    localparam logic [1:0] RESP_HIT   = 2'd1;
    localparam logic [1:0] RESP_HITM  = 2'd2;

    localparam logic [2:0] BUS_WRITE = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP,
        ST_WB,
        ST_UPDATE
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [PA_BITS-1:0]   addr_q, addr_d;
    logic [WAY_W-1:0]     way_q, way_d;
    logic [1:0]           resp_q, resp_d;
    logic                 upd_q, upd_d;
    logic [1:0]           new_mesi_q, new_mesi_d;
    logic                 snp_err_q, snp_err_d;
    logic [15:0]          snp_cnt_q, snp_cnt_d;
    logic [15:0]          hitm_cnt_q, hitm_cnt_d;

    // Lookup outcome decoded from the tag result and the latched command
    logic [1:0]           dec_resp;
    logic                 dec_upd;
    logic [1:0]           dec_mesi;
    logic                 dec_err;

    // Snoop-vs-MESI decision table; an invalid line counts as a miss
    always_comb begin
        dec_resp = RESP_NOHIT;
        dec_upd  = 1'b0;
        dec_mesi = MESI_INV;
        dec_err  = 1'b0;
        if (tl_hit && (tl_mesi != MESI_INV)) begin
            case (cmd_q)
                CMD_RD: begin
                    if (tl_mesi == MESI_MOD) begin
                        dec_resp = RESP_HITM;
                        dec_upd  = 1'b1;
                        dec_mesi = MESI_SHRD;
                    end else if (tl_mesi == MESI_EXCL) begin
                        dec_resp = RESP_HIT;
                        dec_upd  = 1'b1;
                        dec_mesi = MESI_SHRD;
                    end else begin
                        dec_resp = RESP_HIT;
                    end
                end
                CMD_RWIM: begin
                    dec_resp = (tl_mesi == MESI_MOD) ? RESP_HITM : RESP_HIT;
                    dec_upd  = 1'b1;
                    dec_mesi = MESI_INV;
                end
                CMD_INV: begin
                    if (tl_mesi == MESI_SHRD) begin
                        dec_resp = RESP_HIT;
                        dec_upd  = 1'b1;
                        dec_mesi = MESI_INV;
                    end else begin
                        // Invalidate snoop hitting an owned line is illegal
                        dec_err = 1'b1;
                    end
                end
                CMD_WR: begin
                    dec_err = (tl_mesi == MESI_MOD);
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and register updates for the snoop sequencer
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        way_d      = way_q;
        resp_d     = resp_q;
        upd_d      = upd_q;
        new_mesi_d = new_mesi_q;
        snp_err_d  = 1'b0;
        snp_cnt_d  = snp_cnt_q;
        hitm_cnt_d = hitm_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (snp_valid) begin
                    cmd_d     = snp_cmd;
                    addr_d    = snp_addr;
                    snp_cnt_d = snp_cnt_q + 16'd1;
                    if ((snp_cmd >= CMD_INV) && (snp_cmd <= CMD_RWIM)) begin
                        state_d = ST_LOOKUP;
                    end else begin
                        snp_err_d = 1'b1;
                    end
                end
            end
            ST_LOOKUP: begin
                if (tl_ack) begin
                    way_d      = tl_way;
                    resp_d     = dec_resp;
                    upd_d      = dec_upd;
                    new_mesi_d = dec_mesi;
                    snp_err_d  = dec_err;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_q == RESP_HITM) begin
                    if (hitm_cnt_q != 16'hFFFF) begin
                        hitm_cnt_d = hitm_cnt_q + 16'd1;
                    end
                    state_d = ST_WB;
                end else if (upd_q) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (bus_gnt) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            way_q      <= '0;
            resp_q     <= RESP_NOHIT;
            upd_q      <= 1'b0;
            new_mesi_q <= MESI_INV;
            snp_err_q  <= 1'b0;
            snp_cnt_q  <= '0;
            hitm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            way_q      <= way_d;
            resp_q     <= resp_d;
            upd_q      <= upd_d;
            new_mesi_q <= new_mesi_d;
            snp_err_q  <= snp_err_d;
            snp_cnt_q  <= snp_cnt_d;
            hitm_cnt_q <= hitm_cnt_d;
        end
    end

    // Outputs decode directly from state so reset drops them immediately
    always_comb begin
        snp_ready      = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        tl_req         = (state_q == ST_LOOKUP);
        tl_addr        = (state_q == ST_LOOKUP) ? addr_q : '0;
        snp_resp_valid = (state_q == ST_RESP);
        snp_resp       = (state_q == ST_RESP) ? resp_q : RESP_NOHIT;
        bus_req        = (state_q == ST_WB);
        bus_op         = (state_q == ST_WB) ? BUS_WRITE : 3'd0;
        bus_addr       = (state_q == ST_WB) ? {addr_q[PA_BITS-1:OFF_W], {OFF_W{1'b0}}} : '0;
        tu_we          = (state_q == ST_UPDATE);
        tu_addr        = (state_q == ST_UPDATE) ? addr_q : '0;
        tu_way         = (state_q == ST_UPDATE) ? way_q : '0;
        tu_mesi        = (state_q == ST_UPDATE) ? new_mesi_q : MESI_INV;
        snp_err        = snp_err_q;
        snp_cnt        = snp_cnt_q;
        hitm_cnt       = hitm_cnt_q;
    end

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Directed testbench for l2_snoop_responder: inputs driven and outputs sampled
// on the falling clock edge.
module tb_l2_snoop_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snp_valid;
    logic        snp_ready;
    logic [3:0]  snp_cmd;
    logic [31:0] snp_addr;
    logic        tl_req;
    logic [31:0] tl_addr;
    logic        tl_ack;
    logic        tl_hit;
    logic [2:0]  tl_way;
    logic [1:0]  tl_mesi;
    logic        tu_we;
    logic [31:0] tu_addr;
    logic [2:0]  tu_way;
    logic [1:0]  tu_mesi;
    logic        snp_resp_valid;
    logic [1:0]  snp_resp;
    logic        bus_req;
    logic [2:0]  bus_op;
    logic [31:0] bus_addr;
    logic        bus_gnt;
    logic        snp_err;
    logic        busy;
    logic [15:0] snp_cnt;
    logic [15:0] hitm_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_snoop_responder dut (
        .clk(clk), .rst_n(rst_n),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
        .tl_req(tl_req), .tl_addr(tl_addr), .tl_ack(tl_ack), .tl_hit(tl_hit),
        .tl_way(tl_way), .tl_mesi(tl_mesi),
        .tu_we(tu_we), .tu_addr(tu_addr), .tu_way(tu_way), .tu_mesi(tu_mesi),
        .snp_resp_valid(snp_resp_valid), .snp_resp(snp_resp),
        .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr), .bus_gnt(bus_gnt),
        .snp_err(snp_err), .busy(busy), .snp_cnt(snp_cnt), .hitm_cnt(hitm_cnt)
    );

    // Stimulus only: one SNP_RD hitting a MOD line, ack and grant given at once.
    // Returns on the falling edge of the cycle the responder is idle again.
    task automatic do_hitm_snoop(input logic [31:0] addr);
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = 4'd4; snp_addr = addr;
        @(negedge clk);
        snp_valid = 1'b0;
        tl_ack = 1'b1; tl_hit = 1'b1; tl_way = 3'd1; tl_mesi = 2'd1;
        @(negedge clk);
        tl_ack = 1'b0; tl_hit = 1'b0;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        snp_valid = 1'b0; snp_cmd = 4'd0; snp_addr = 32'd0;
        tl_ack = 1'b0; tl_hit = 1'b0; tl_way = 3'd0; tl_mesi = 2'd0; bus_gnt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({snp_ready, tl_req, tu_we, snp_resp_valid, snp_resp, bus_req, bus_op, snp_err, busy} !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 100000000000",
                     {snp_ready, tl_req, tu_we, snp_resp_valid, snp_resp, bus_req, bus_op, snp_err, busy});
        end
        checks++;
        if ({tl_addr, tu_addr, bus_addr, tu_way, tu_mesi, snp_cnt, hitm_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0",
                     {tl_addr, tu_addr, bus_addr, tu_way, tu_mesi, snp_cnt, hitm_cnt});
        end
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_rd_hitm();
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = 4'd4; snp_addr = 32'h0000_1234;
        @(negedge clk);
        snp_valid = 1'b0;
        checks++;
        if ({tl_req, tl_addr, snp_cnt} !== {1'b1, 32'h0000_1234, 16'd1}) begin
            errors++;
            $display("FAIL rd_lookup: got req=%b addr=%h cnt=%0d expected req=1 addr=00001234 cnt=1", tl_req, tl_addr, snp_cnt);
        end
        tl_ack = 1'b1; tl_hit = 1'b1; tl_way = 3'd5; tl_mesi = 2'd1;
        @(negedge clk);
        tl_ack = 1'b0; tl_hit = 1'b0;
        checks++;
        if ({snp_resp_valid, snp_resp, bus_req, tu_we} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rd_resp: got valid=%b resp=%0d bus_req=%b tu_we=%b expected 1 2 0 0", snp_resp_valid, snp_resp, bus_req, tu_we);
        end
        @(negedge clk);
        checks++;
        if ({bus_req, bus_op, bus_addr, snp_resp_valid, snp_resp, hitm_cnt} !== {1'b1, 3'd2, 32'h0000_1200, 1'b0, 2'd0, 16'd1}) begin
            errors++;
            $display("FAIL rd_wb: got req=%b op=%0d addr=%h rv=%b resp=%0d hitm=%0d expected 1 2 00001200 0 0 1",
                     bus_req, bus_op, bus_addr, snp_resp_valid, snp_resp, hitm_cnt);
        end
        @(negedge clk);
        checks++;
        if ({bus_req, bus_addr, tu_we} !== {1'b1, 32'h0000_1200, 1'b0}) begin
            errors++;
            $display("FAIL rd_wb_hold: got req=%b addr=%h tu_we=%b expected 1 00001200 0", bus_req, bus_addr, tu_we);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        checks++;
        if ({bus_req, bus_op, tu_we, tu_addr, tu_way, tu_mesi} !== {1'b0, 3'd0, 1'b1, 32'h0000_1234, 3'd5, 2'd3}) begin
            errors++;
            $display("FAIL rd_update: got req=%b op=%0d we=%b addr=%h way=%0d mesi=%0d expected 0 0 1 00001234 5 3",
                     bus_req, bus_op, tu_we, tu_addr, tu_way, tu_mesi);
        end
        @(negedge clk);
        checks++;
        if ({snp_ready, busy, tu_we} !== 3'b100) begin
            errors++;
            $display("FAIL rd_done: got ready=%b busy=%b we=%b expected 1 0 0", snp_ready, busy, tu_we);
        end
        $display("rd_hitm: addr=00001234 resp=HITM wb=00001200 hitm_cnt=%0d", hitm_cnt);
    endtask

    task automatic test_rwim_hit();
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = 4'd6; snp_addr = 32'h0000_ABC0;
        @(negedge clk);
        snp_valid = 1'b0;
        tl_ack = 1'b1; tl_hit = 1'b1; tl_way = 3'd2; tl_mesi = 2'd3;
        @(negedge clk);
        tl_ack = 1'b0; tl_hit = 1'b0;
        checks++;
        if ({snp_resp_valid, snp_resp} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL rwim_resp: got valid=%b resp=%0d expected 1 1", snp_resp_valid, snp_resp);
        end
        @(negedge clk);
        checks++;
        if ({tu_we, tu_way, tu_mesi, tu_addr, bus_req, snp_ready, snp_resp_valid} !== {1'b1, 3'd2, 2'd0, 32'h0000_ABC0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rwim_update: got we=%b way=%0d mesi=%0d addr=%h bus=%b ready=%b rv=%b expected 1 2 0 0000abc0 0 0 0",
                     tu_we, tu_way, tu_mesi, tu_addr, bus_req, snp_ready, snp_resp_valid);
        end
        @(negedge clk);
        checks++;
        if ({snp_ready, tu_we, snp_cnt, hitm_cnt} !== {1'b1, 1'b0, 16'd2, 16'd1}) begin
            errors++;
            $display("FAIL rwim_done: got ready=%b we=%b cnt=%0d hitm=%0d expected 1 0 2 1", snp_ready, tu_we, snp_cnt, hitm_cnt);
        end
        $display("rwim_hit: resp=HIT new_mesi=INV way=2");
    endtask

    task automatic test_inv_err();
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = 4'd3; snp_addr = 32'h0000_2040;
        @(negedge clk);
        snp_valid = 1'b0;
        tl_ack = 1'b1; tl_hit = 1'b1; tl_way = 3'd3; tl_mesi = 2'd2;
        @(negedge clk);
        tl_ack = 1'b0; tl_hit = 1'b0;
        checks++;
        if ({snp_resp_valid, snp_resp, snp_err} !== {1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL inv_resp: got valid=%b resp=%0d err=%b expected 1 0 1", snp_resp_valid, snp_resp, snp_err);
        end
        @(negedge clk);
        checks++;
        if ({tu_we, snp_err, snp_ready} !== 3'b001) begin
            errors++;
            $display("FAIL inv_done: got we=%b err=%b ready=%b expected 0 0 1", tu_we, snp_err, snp_ready);
        end
        snp_valid = 1'b1; snp_cmd = 4'd7; snp_addr = 32'h0000_3000;
        @(negedge clk);
        snp_valid = 1'b0;
        checks++;
        if ({snp_err, tl_req, snp_ready, busy, snp_cnt} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'd4}) begin
            errors++;
            $display("FAIL badcmd: got err=%b tl_req=%b ready=%b busy=%b cnt=%0d expected 1 0 1 0 4",
                     snp_err, tl_req, snp_ready, busy, snp_cnt);
        end
        @(negedge clk);
        checks++;
        if ({snp_err, tl_req, snp_resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL badcmd_after: got err=%b tl_req=%b rv=%b expected 0 0 0", snp_err, tl_req, snp_resp_valid);
        end
        $display("inv_err: INV on EXCL -> NOHIT+err, cmd 7 -> err");
    endtask

    task automatic test_miss_delay();
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = 4'd4; snp_addr = 32'h0000_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            snp_valid = 1'b0;
            checks++;
            if ({tl_req, tl_addr, snp_resp_valid} !== {1'b1, 32'h0000_5678, 1'b0}) begin
                errors++;
                $display("FAIL miss_hold%0d: got req=%b addr=%h rv=%b expected 1 00005678 0", i, tl_req, tl_addr, snp_resp_valid);
            end
        end
        @(negedge clk);
        tl_ack = 1'b1; tl_hit = 1'b0; tl_way = 3'd6; tl_mesi = 2'd1;
        @(negedge clk);
        tl_ack = 1'b0;
        checks++;
        if ({snp_resp_valid, snp_resp, tl_req, tu_we} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL miss_resp: got valid=%b resp=%0d tl_req=%b we=%b expected 1 0 0 0", snp_resp_valid, snp_resp, tl_req, tu_we);
        end
        @(negedge clk);
        checks++;
        if ({snp_ready, tu_we, bus_req, hitm_cnt} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL miss_done: got ready=%b we=%b bus=%b hitm=%0d expected 1 0 0 1", snp_ready, tu_we, bus_req, hitm_cnt);
        end
        $display("miss_delay: ack after 5 wait cycles, resp=NOHIT");
    endtask

    task automatic test_stray_handshakes();
        @(negedge clk);
        tl_ack = 1'b1; tl_hit = 1'b1; tl_mesi = 2'd1; bus_gnt = 1'b1;
        @(negedge clk);
        tl_ack = 1'b0; tl_hit = 1'b0; bus_gnt = 1'b0;
        checks++;
        if ({busy, snp_resp_valid, tu_we, bus_req, bus_op} !== 7'b0) begin
            errors++;
            $display("FAIL stray: got busy=%b rv=%b we=%b bus=%b op=%0d expected all 0", busy, snp_resp_valid, tu_we, bus_req, bus_op);
        end
        $display("stray: ack/gnt in IDLE ignored");
    endtask

    task automatic test_reset_in_wb();
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = 4'd4; snp_addr = 32'h0000_7F40;
        @(negedge clk);
        snp_valid = 1'b0;
        tl_ack = 1'b1; tl_hit = 1'b1; tl_way = 3'd4; tl_mesi = 2'd1;
        @(negedge clk);
        tl_ack = 1'b0; tl_hit = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rstwb_pre: got bus_req=%b expected 1", bus_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_op, snp_ready, busy, snp_cnt, hitm_cnt} !== {1'b0, 3'd0, 1'b1, 1'b0, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL rstwb_drop: got bus=%b op=%0d ready=%b busy=%b cnt=%0d hitm=%0d expected 0 0 1 0 0 0",
                     bus_req, bus_op, snp_ready, busy, snp_cnt, hitm_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({tu_we, snp_resp_valid, bus_req, snp_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rstwb_after: got we=%b rv=%b bus=%b ready=%b expected 0 0 0 1", tu_we, snp_resp_valid, bus_req, snp_ready);
        end
        $display("reset_in_wb: writeback abandoned");
    endtask

    task automatic test_counter_limits();
        @(negedge clk);
        force dut.hitm_cnt_q = 16'hFFFE;
        #1 release dut.hitm_cnt_q;
        do_hitm_snoop(32'h0000_0100);
        checks++;
        if (hitm_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL hitm_reach_max: got %h expected ffff", hitm_cnt);
        end
        do_hitm_snoop(32'h0000_0140);
        checks++;
        if (hitm_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL hitm_saturate: got %h expected ffff", hitm_cnt);
        end
        force dut.snp_cnt_q = 16'hFFFF;
        #1 release dut.snp_cnt_q;
        @(negedge clk);
        snp_valid = 1'b1; snp_cmd = 4'd0; snp_addr = 32'h0;
        @(negedge clk);
        snp_valid = 1'b0;
        checks++;
        if ({snp_cnt, snp_err} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL snp_cnt_wrap: got cnt=%h err=%b expected 0000 1", snp_cnt, snp_err);
        end
        $display("counters: hitm_cnt=%h snp_cnt=%h", hitm_cnt, snp_cnt);
    endtask

    initial begin
        test_reset();
        test_rd_hitm();
        test_rwim_hit();
        test_inv_err();
        test_miss_delay();
        test_stray_handshakes();
        test_reset_in_wb();
        test_counter_limits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
